// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Purpose  : Round-robin share of one multi-byte UART serializer among
//            NUM_REQ requesters; prepends a 0xA<id> header byte.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int BYTES         = 4,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [NUM_REQ-1:0]           req_in,
    input  logic [NUM_REQ*8*BYTES-1:0]   data_in,
    output logic [NUM_REQ-1:0]           grant_out,
    output logic [NUM_REQ-1:0]           done_out,
    output logic                         ser_ready_out,
    output logic [8*(BYTES+1)-1:0]       ser_data_out,
    input  logic                         ser_busy_in,
    output logic                         active_out,
    output logic                         err_out,
    input  logic                         err_clr_in
);

    localparam int c_PAY_W = 8 * BYTES;
    localparam int c_CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_rr_ptr;
    logic [3:0]           r_owner;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_found;
    logic [3:0]           w_winner;
    logic [3:0]           w_rr_nxt;
    logic [c_PAY_W-1:0]   w_payload;
    logic                 w_do_grant;
    logic                 w_ready_nxt;
    logic                 w_done_nxt;
    logic                 w_err_set;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;

    // Smallest offset from the pointer wins: later (smaller k) hits overwrite.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((r_rr_ptr == 4'(j)) && req_in[(j + k) % NUM_REQ]) begin
                    w_found  = 1'b1;
                    w_winner = 4'((j + k) % NUM_REQ);
                end
            end
        end
    end

    always_comb begin
        w_payload = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_winner == 4'(j)) begin
                w_payload = data_in[j*c_PAY_W +: c_PAY_W];
            end
        end
    end

    assign w_rr_nxt = (w_winner == 4'(NUM_REQ - 1)) ? 4'd0 : (w_winner + 4'd1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_grant  = 1'b0;
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_set   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !ser_busy_in) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_ready_nxt = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (ser_busy_in) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!ser_busy_in) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            grant_out     <= '0;
            done_out      <= '0;
            ser_ready_out <= 1'b0;
            ser_data_out  <= '0;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_cnt         <= '0;
            err_out       <= 1'b0;
        end else begin
            grant_out     <= w_do_grant ? (c_ONE << w_winner) : '0;
            done_out      <= w_done_nxt ? (c_ONE << r_owner) : '0;
            ser_ready_out <= w_ready_nxt;
            if (w_do_grant) begin
                ser_data_out <= {w_payload, 4'hA, w_winner};
                r_owner      <= w_winner;
                r_rr_ptr     <= w_rr_nxt;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A timeout in the same cycle as a clear request keeps the flag set.
            if (w_err_set) begin
                err_out <= 1'b1;
            end else if (err_clr_in) begin
                err_out <= 1'b0;
            end
        end
    end

    assign active_out = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_arbiter
// Purpose  : Self-checking bench for serial_tx_arbiter with a serializer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arbiter;

    localparam int N  = 4;
    localparam int BY = 4;
    localparam int TO = 16;
    localparam int PW = 8 * BY;
    localparam int SW = 8 * (BY + 1);

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [N-1:0]      req_in;
    logic [N*PW-1:0]   data_in;
    logic [N-1:0]      grant_out;
    logic [N-1:0]      done_out;
    logic              ser_ready_out;
    logic [SW-1:0]     ser_data_out;
    logic              ser_busy_in;
    logic              active_out;
    logic              err_out;
    logic              err_clr_in;

    always #5 clk_in = ~clk_in;

    serial_tx_arbiter #(
        .NUM_REQ      (N),
        .BYTES        (BY),
        .START_TIMEOUT(TO)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .req_in       (req_in),
        .data_in      (data_in),
        .grant_out    (grant_out),
        .done_out     (done_out),
        .ser_ready_out(ser_ready_out),
        .ser_data_out (ser_data_out),
        .ser_busy_in  (ser_busy_in),
        .active_out   (active_out),
        .err_out      (err_out),
        .err_clr_in   (err_clr_in)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Transaction-level reference: who owns the serializer and since when.
    int          m_ptr, m_owner, m_gcyc, m_ngrants;
    bit          m_inflight, m_seen, m_err;
    logic [SW-1:0] m_pkt;

    // Serializer model: 0 = auto respond, 1 = busy driven by test, 2 = never busy.
    int ser_mode, ser_phase, ser_cnt, ser_len, ser_d_cfg, ser_l_cfg;
    bit ser_rand;

    function automatic int rr_search(input logic [N-1:0] rq, input int ptr);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (rq[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr      = 0;
        m_owner    = 0;
        m_gcyc     = 0;
        m_inflight = 1'b0;
        m_seen     = 1'b0;
        m_err      = 1'b0;
        m_pkt      = '0;
        ser_phase  = 0;
        ser_cnt    = 0;
        if (ser_mode != 1) ser_busy_in = 1'b0;
    endtask

    // One clock: snapshot what the DUT samples, advance, check against the model.
    task automatic step();
        logic [N-1:0]    rq, eg, ed;
        logic [N*PW-1:0] dt;
        logic            bz, clr, rs, er;
        bit              tmo;
        int              w;
        rq = req_in; dt = data_in; bz = ser_busy_in; clr = err_clr_in; rs = rst_n_in;
        @(posedge clk_in);
        #1;
        cyc++;
        if (!rs) begin
            n_total++;
            if ({grant_out, done_out, ser_ready_out, ser_data_out, active_out, err_out} !== '0)
                $display("FAIL reset_hold: got g=%b d=%b r=%b data=%h a=%b e=%b expected all zero",
                         grant_out, done_out, ser_ready_out, ser_data_out, active_out, err_out);
            else n_pass++;
            model_reset();
            return;
        end
        eg = '0; ed = '0; tmo = 1'b0;
        if (!m_inflight) begin
            if (|rq && !bz) begin
                w = rr_search(rq, m_ptr);
                eg[w]      = 1'b1;
                m_ptr      = (w + 1) % N;
                m_owner    = w;
                m_gcyc     = cyc;
                m_inflight = 1'b1;
                m_seen     = 1'b0;
                m_pkt      = {dt[w*PW +: PW], 4'hA, 4'(w)};
                m_ngrants++;
            end
        end else if (cyc >= m_gcyc + 2) begin
            if (m_seen && !bz) begin
                ed[m_owner] = 1'b1;
                m_inflight  = 1'b0;
            end else if (!m_seen && bz) begin
                m_seen = 1'b1;
            end else if (!m_seen && cyc == m_gcyc + 1 + TO) begin
                tmo        = 1'b1;
                m_inflight = 1'b0;
            end
        end
        er    = m_inflight && (cyc == m_gcyc + 1);
        m_err = tmo ? 1'b1 : (clr ? 1'b0 : m_err);

        n_total++;
        if (grant_out !== eg) $display("FAIL model_grant @%0d: got %b expected %b", cyc, grant_out, eg);
        else n_pass++;
        n_total++;
        if (done_out !== ed) $display("FAIL model_done @%0d: got %b expected %b", cyc, done_out, ed);
        else n_pass++;
        n_total++;
        if (ser_ready_out !== er) $display("FAIL model_ready @%0d: got %b expected %b", cyc, ser_ready_out, er);
        else n_pass++;
        n_total++;
        if (ser_data_out !== m_pkt) $display("FAIL model_data @%0d: got %h expected %h", cyc, ser_data_out, m_pkt);
        else n_pass++;
        n_total++;
        if (active_out !== m_inflight) $display("FAIL model_active @%0d: got %b expected %b", cyc, active_out, m_inflight);
        else n_pass++;
        n_total++;
        if (err_out !== m_err) $display("FAIL model_err @%0d: got %b expected %b", cyc, err_out, m_err);
        else n_pass++;

        if (ser_mode == 0) begin
            if (ser_ready_out && ser_phase == 0) begin
                ser_phase = 1;
                if (ser_rand) begin
                    ser_cnt = $urandom_range(0, 4);
                    ser_len = $urandom_range(1, 6);
                end else begin
                    ser_cnt = ser_d_cfg;
                    ser_len = ser_l_cfg;
                end
            end
            if (ser_phase == 1) begin
                if (ser_cnt == 0) begin
                    ser_busy_in = 1'b1;
                    ser_phase   = 2;
                    ser_cnt     = ser_len;
                end else ser_cnt--;
            end else if (ser_phase == 2) begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    ser_busy_in = 1'b0;
                    ser_phase   = 0;
                end
            end
        end else if (ser_mode == 2) begin
            ser_busy_in = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
    endtask

    task automatic wait_grant();
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (grant_out != '0) got = 1'b1;
        end
        n_total++;
        if (!got) $display("FAIL wait_grant: got no grant expected one within 20 cycles");
        else n_pass++;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 200 && !idle; k++) begin
            step();
            if (!active_out && !m_inflight) idle = 1'b1;
        end
        n_total++;
        if (!idle) $display("FAIL wait_idle: got active=%b expected idle within 200 cycles", active_out);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; req_in = '0; data_in = '0; err_clr_in = 1'b0;
        ser_busy_in = 1'b0; ser_mode = 0; ser_rand = 1'b1; ser_d_cfg = 0; ser_l_cfg = 1;
        m_ngrants = 0;
        model_reset();
        #2;
        n_total++;
        if ({grant_out, done_out, ser_ready_out, ser_data_out, active_out, err_out} !== '0)
            $display("FAIL reset_state: got g=%b d=%b data=%h a=%b e=%b expected zero",
                     grant_out, done_out, ser_data_out, active_out, err_out);
        else n_pass++;
        step();
        rst_n_in = 1'b1;
        step();
    endtask

    task automatic test_single();
        int ndone = 0;
        logic [N-1:0] lastd = '0;
        do_reset();
        ser_rand = 1'b0; ser_d_cfg = 3; ser_l_cfg = 50;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        data_in[2*PW +: PW] = 32'hDEADBEEF;
        req_in = 4'b0100;
        wait_grant();
        n_total++;
        if (grant_out !== 4'b0100) $display("FAIL single_grant: got %b expected %b", grant_out, 4'b0100);
        else n_pass++;
        n_total++;
        if (ser_data_out !== 40'hDEADBEEF_A2) $display("FAIL single_data: got %h expected %h", ser_data_out, 40'hDEADBEEF_A2);
        else n_pass++;
        req_in = '0;
        step();
        n_total++;
        if (ser_ready_out !== 1'b1) $display("FAIL single_ready: got %b expected 1", ser_ready_out);
        else n_pass++;
        step();
        n_total++;
        if (ser_ready_out !== 1'b0) $display("FAIL single_ready_width: got %b expected 0", ser_ready_out);
        else n_pass++;
        for (int k = 0; k < 100; k++) begin
            step();
            if (done_out != '0) begin ndone++; lastd = done_out; end
        end
        n_total++;
        if (ndone !== 1 || lastd !== 4'b0100) $display("FAIL single_done: got %0d pulses last=%b expected 1 pulse 0100", ndone, lastd);
        else n_pass++;
        n_total++;
        if (ser_data_out !== 40'hDEADBEEF_A2) $display("FAIL single_data_hold: got %h expected %h", ser_data_out, 40'hDEADBEEF_A2);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int order[5];
        int cnt = 0;
        do_reset();
        ser_rand = 1'b1;
        req_in = 4'hF;
        for (int k = 0; k < 400 && cnt < 5; k++) begin
            step();
            if (grant_out != '0) begin order[cnt] = onehot_idx(grant_out); cnt++; end
        end
        n_total++;
        if (cnt !== 5) $display("FAIL rr_count: got %0d grants expected 5", cnt);
        else n_pass++;
        for (int i = 0; i < cnt; i++) begin
            n_total++;
            if (order[i] !== i % N) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % N);
            else n_pass++;
        end
        req_in = '0;
        wait_idle();
    endtask

    task automatic test_skip();
        int got[2];
        int cnt = 0;
        int n1  = 0;
        do_reset();
        ser_rand = 1'b0; ser_d_cfg = 2; ser_l_cfg = 4;
        req_in = 4'b0001;
        wait_grant();
        req_in = 4'b0010;
        step();
        step();
        req_in = 4'b0000;
        wait_idle();
        req_in = 4'b1001;
        for (int k = 0; k < 200 && cnt < 2; k++) begin
            step();
            if (grant_out[1]) n1++;
            if (grant_out != '0) begin got[cnt] = onehot_idx(grant_out); cnt++; end
            req_in = req_in & ~grant_out;
        end
        n_total++;
        if (cnt !== 2 || got[0] !== 3 || got[1] !== 0)
            $display("FAIL skip_order: got %0d grants first=%0d second=%0d expected 3 then 0", cnt, got[0], got[1]);
        else n_pass++;
        n_total++;
        if (n1 !== 0) $display("FAIL skip_dropped: got %0d grants to 1 expected 0", n1);
        else n_pass++;
        req_in = '0;
        wait_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        ser_mode = 2;
        for (int pass = 0; pass < 2; pass++) begin
            err_clr_in = (pass == 1);
            req_in = 4'b0001;
            wait_grant();
            req_in = '0;
            step();
            for (int k = 1; k <= TO; k++) begin
                step();
                n_total++;
                if (err_out !== (k == TO)) $display("FAIL timeout_err p%0d k%0d: got %b expected %b", pass, k, err_out, k == TO);
                else n_pass++;
                n_total++;
                if (done_out !== '0) $display("FAIL timeout_done p%0d: got %b expected 0", pass, done_out);
                else n_pass++;
            end
            n_total++;
            if (active_out !== 1'b0) $display("FAIL timeout_idle p%0d: got %b expected 0", pass, active_out);
            else n_pass++;
            err_clr_in = 1'b1;
            step();
            n_total++;
            if (err_out !== 1'b0) $display("FAIL timeout_clear p%0d: got %b expected 0", pass, err_out);
            else n_pass++;
            err_clr_in = 1'b0;
        end
        ser_mode = 0;
    endtask

    task automatic test_busy_idle();
        do_reset();
        ser_mode = 1; ser_busy_in = 1'b1; ser_rand = 1'b1;
        req_in = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            n_total++;
            if (grant_out !== '0) $display("FAIL busy_nogrant k%0d: got %b expected 0", k, grant_out);
            else n_pass++;
        end
        ser_busy_in = 1'b0;
        ser_mode = 0;
        step();
        n_total++;
        if (grant_out !== 4'b0001) $display("FAIL busy_release_grant: got %b expected %b", grant_out, 4'b0001);
        else n_pass++;
        req_in = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        do_reset();
        ser_rand = 1'b0; ser_d_cfg = 1; ser_l_cfg = 20;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        req_in = 4'b0100;
        wait_grant();
        req_in = '0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = m_seen;
        end
        step();
        #3;
        rst_n_in = 1'b0;
        #1;
        n_total++;
        if ({grant_out, done_out, ser_ready_out} !== '0) $display("FAIL midrst_pulses: got g=%b d=%b r=%b expected 0", grant_out, done_out, ser_ready_out);
        else n_pass++;
        n_total++;
        if (ser_data_out !== '0) $display("FAIL midrst_data: got %h expected 0", ser_data_out);
        else n_pass++;
        n_total++;
        if (active_out !== 1'b0 || err_out !== 1'b0) $display("FAIL midrst_state: got a=%b e=%b expected 0 0", active_out, err_out);
        else n_pass++;
        step();
        req_in = 4'b1010;
        rst_n_in = 1'b1;
        step();
        n_total++;
        if (grant_out !== 4'b0010) $display("FAIL midrst_ptr: got %b expected %b", grant_out, 4'b0010);
        else n_pass++;
        req_in = '0;
        wait_idle();
    endtask

    task automatic test_random();
        int ngr = 0;
        do_reset();
        m_ngrants = 0;
        ser_mode = 0; ser_rand = 1'b1;
        req_in = '0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (grant_out != '0) ngr++;
            for (int i = 0; i < N; i++) begin
                if (req_in[i]) begin
                    if (grant_out[i]) begin
                        if ($urandom_range(0, 1) == 0) req_in[i] = 1'b0;
                    end else if ($urandom_range(0, 19) == 0) begin
                        req_in[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req_in[i] = 1'b1;
                    data_in[i*PW +: PW] = $urandom;
                end
            end
            err_clr_in = ($urandom_range(0, 7) == 0);
        end
        req_in = '0;
        err_clr_in = 1'b0;
        wait_idle();
        n_total++;
        if (ngr !== m_ngrants) $display("FAIL random_grant_count: got %0d expected %0d", ngr, m_ngrants);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_timeout();
        test_busy_idle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
